operand_bank: RTL and testbench

Parametrised successor to the single operand-A latch. Holds NREG operand registers of DW bits each and serves two operand reads (A and B) per request. Reads are presented through a registered output stage with a valid/ready handshake and write-to-read bypass. Sits between the register-write path and the ALU input of the 16-bit RISC datapath.

---
 rtl/operand_bank.sv | 119 +++++++++++
 tb/tb_operand_bank.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/operand_bank.sv
// ============================================================================
// Module   : operand_bank
// Brief    : NREG x DW operand register bank with dual registered reads,
//            valid/ready output handshake and write-to-read bypass.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_bank #(
  parameter int DW   = 16,
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          clr,
  input  logic          rd_req,
  output logic          rd_rdy,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] opa,
  output logic [DW-1:0] opb,
  output logic          opa_unw,
  output logic          opb_unw,
  output logic          out_valid,
  input  logic          out_ready
);

  logic [DW-1:0]   regs_q [NREG];
  logic [NREG-1:0] written_q;

  logic [DW-1:0] opa_q, opa_d;
  logic [DW-1:0] opb_q, opb_d;
  logic          unwa_q, unwa_d;
  logic          unwb_q, unwb_d;
  logic          valid_q, valid_d;
  logic          w_fire;

  // Write beats clear for its own address; every other entry is cleared.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        regs_q[gi]    <= '0;
        written_q[gi] <= 1'b0;
      end else if (we && (waddr == AW'(gi))) begin
        regs_q[gi]    <= wdata;
        written_q[gi] <= 1'b1;
      end else if (clr) begin
        regs_q[gi]    <= '0;
        written_q[gi] <= 1'b0;
      end
    end
  end

  assign rd_rdy = !valid_q || out_ready;
  assign w_fire = rd_req && rd_rdy;

  always_comb begin
    opa_d   = opa_q;
    opb_d   = opb_q;
    unwa_d  = unwa_q;
    unwb_d  = unwb_q;
    valid_d = valid_q;
    if (w_fire) begin
      valid_d = 1'b1;
      // Read sees the bank as it will be after this edge's clear/write.
      if (we && (waddr == raddr_a)) begin
        opa_d  = wdata;
        unwa_d = 1'b0;
      end else if (clr) begin
        opa_d  = '0;
        unwa_d = 1'b1;
      end else begin
        opa_d  = regs_q[raddr_a];
        unwa_d = !written_q[raddr_a];
      end
      if (we && (waddr == raddr_b)) begin
        opb_d  = wdata;
        unwb_d = 1'b0;
      end else if (clr) begin
        opb_d  = '0;
        unwb_d = 1'b1;
      end else begin
        opb_d  = regs_q[raddr_b];
        unwb_d = !written_q[raddr_b];
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opa_q   <= '0;
      opb_q   <= '0;
      unwa_q  <= 1'b0;
      unwb_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      unwa_q  <= unwa_d;
      unwb_q  <= unwb_d;
      valid_q <= valid_d;
    end
  end

  assign opa       = opa_q;
  assign opb       = opb_q;
  assign opa_unw   = unwa_q;
  assign opb_unw   = unwb_q;
  assign out_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_operand_bank.sv
// ============================================================================
// Module   : tb_operand_bank
// Brief    : Directed self-checking bench for operand_bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_bank;

  localparam int DW = 16;
  localparam int NREG = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n, we, clr, rd_req, out_ready;
  logic [AW-1:0] waddr, raddr_a, raddr_b;
  logic [DW-1:0] wdata;
  logic          rd_rdy, opa_unw, opb_unw, out_valid;
  logic [DW-1:0] opa, opb;

  int total = 0;
  int bad   = 0;

  operand_bank #(.DW(DW), .NREG(NREG), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .clr(clr), .rd_req(rd_req), .rd_rdy(rd_rdy), .raddr_a(raddr_a),
    .raddr_b(raddr_b), .opa(opa), .opb(opb), .opa_unw(opa_unw),
    .opb_unw(opb_unw), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [AW-1:0] b);
    rd_req = 1'b1; raddr_a = a; raddr_b = b;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1; waddr = a; wdata = d;
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; clr = 1'b0; rd_req = 1'b0; out_ready = 1'b1;
    waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;

    // 1. reset then idle read of unwritten registers
    step(); step();
    chk("rst_opa", 32'(opa), 32'h0);
    chk("rst_opb", 32'(opb), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_rdy", 32'(rd_rdy), 32'h1);
    rst_n = 1'b1;
    rd(3'd0, 3'd7);
    step(); rd_req = 1'b0;
    chk("t1_opa", 32'(opa), 32'h0);
    chk("t1_opb", 32'(opb), 32'h0);
    chk("t1_unwa", 32'(opa_unw), 32'h1);
    chk("t1_unwb", 32'(opb_unw), 32'h1);
    chk("t1_valid", 32'(out_valid), 32'h1);

    // 2. write then read
    wr(3'd3, 16'hBEEF); step();
    chk("t2_valid_drop", 32'(out_valid), 32'h0);
    wr(3'd5, 16'h1234); step(); we = 1'b0;
    rd(3'd3, 3'd5); step(); rd_req = 1'b0;
    chk("t2_opa", 32'(opa), 32'hBEEF);
    chk("t2_opb", 32'(opb), 32'h1234);
    chk("t2_unwa", 32'(opa_unw), 32'h0);
    chk("t2_unwb", 32'(opb_unw), 32'h0);
    chk("t2_valid", 32'(out_valid), 32'h1);
    step();
    chk("t2_valid_idle", 32'(out_valid), 32'h0);

    // 3. bypass on same-cycle write
    wr(3'd2, 16'hA5A5); rd(3'd2, 3'd2); step(); we = 1'b0; rd_req = 1'b0;
    chk("t3_opa", 32'(opa), 32'hA5A5);
    chk("t3_opb", 32'(opb), 32'hA5A5);
    chk("t3_unwa", 32'(opa_unw), 32'h0);
    chk("t3_unwb", 32'(opb_unw), 32'h0);

    // 4. backpressure hold
    rd(3'd3, 3'd2); step(); rd_req = 1'b0; out_ready = 1'b0;
    #1;
    chk("t4_opa", 32'(opa), 32'hBEEF);
    chk("t4_rdy_low", 32'(rd_rdy), 32'h0);
    wr(3'd3, 16'h0000); rd(3'd5, 3'd5); step(); we = 1'b0;
    step(); rd_req = 1'b0;
    chk("t4_hold_opa", 32'(opa), 32'hBEEF);
    chk("t4_hold_opb", 32'(opb), 32'hA5A5);
    chk("t4_hold_valid", 32'(out_valid), 32'h1);
    out_ready = 1'b1; rd(3'd3, 3'd2); step(); rd_req = 1'b0;
    chk("t4_opa_new", 32'(opa), 32'h0000);
    chk("t4_unwa_new", 32'(opa_unw), 32'h0);

    // 5. clear with simultaneous write
    wr(3'd1, 16'h1111); step();
    wr(3'd4, 16'h4444); step();
    clr = 1'b1; wr(3'd4, 16'h9999); step(); clr = 1'b0; we = 1'b0;
    rd(3'd1, 3'd4); step(); rd_req = 1'b0;
    chk("t5_opa", 32'(opa), 32'h0);
    chk("t5_unwa", 32'(opa_unw), 32'h1);
    chk("t5_opb", 32'(opb), 32'h9999);
    chk("t5_unwb", 32'(opb_unw), 32'h0);
    // read firing with clear sees post-clear view plus bypass
    wr(3'd6, 16'h6666); step();
    clr = 1'b1; wr(3'd4, 16'h7777); rd(3'd6, 3'd4); step();
    clr = 1'b0; we = 1'b0; rd_req = 1'b0;
    chk("t5c_opa", 32'(opa), 32'h0);
    chk("t5c_unwa", 32'(opa_unw), 32'h1);
    chk("t5c_opb", 32'(opb), 32'h7777);
    chk("t5c_unwb", 32'(opb_unw), 32'h0);

    // back-to-back full throughput
    wr(3'd7, 16'hC0DE); step(); we = 1'b0;
    rd(3'd7, 3'd4); step();
    chk("b2b_opa0", 32'(opa), 32'hC0DE);
    rd(3'd4, 3'd7); step(); rd_req = 1'b0;
    chk("b2b_opa1", 32'(opa), 32'h7777);
    chk("b2b_opb1", 32'(opb), 32'hC0DE);
    chk("b2b_valid", 32'(out_valid), 32'h1);

    // 6. reset during a stall
    rd(3'd4, 3'd7); step(); rd_req = 1'b0; out_ready = 1'b0;
    step();
    chk("t6_pre_valid", 32'(out_valid), 32'h1);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("t6_valid", 32'(out_valid), 32'h0);
    chk("t6_opa", 32'(opa), 32'h0);
    chk("t6_opb", 32'(opb), 32'h0);
    out_ready = 1'b1; rd(3'd4, 3'd7); step(); rd_req = 1'b0;
    chk("t6_rd_opa", 32'(opa), 32'h0);
    chk("t6_rd_unwa", 32'(opa_unw), 32'h1);
    chk("t6_rd_opb", 32'(opb), 32'h0);
    chk("t6_rd_unwb", 32'(opb_unw), 32'h1);
    chk("t6_rd_valid", 32'(out_valid), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
